// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared word type, frame FSM states and framing constants
package uart_rx_frame_ctrl_pkg;

    localparam int WORD_W = 8;

    typedef logic [WORD_W-1:0] word_length_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_CMD,
        GET_PAYLOAD,
        GET_END,
        ACCEPT,
        ERR
    } rx_frame_state_t;

    localparam word_length_t START_MK    = 8'hFE;
    localparam word_length_t END_MK      = 8'hEF;
    localparam int           MAX_PAYLOAD = 16;
    localparam int           TIMEOUT_CYC = 5208;

endpackage

// File: rtl/cntr_rx_timeout_ovf.sv
// cntr_rx_timeout_ovf: clear/enable counter flagging ovf once LIMIT-1 cycles have elapsed
module cntr_rx_timeout_ovf
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic ovf
);

    localparam int W = $clog2(LIMIT);

    logic [W-1:0] cnt;

    assign ovf = cnt == W'(LIMIT - 1);

    // count idle cycles, saturating at the overflow value until cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !ovf)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses START/LEN/CMD/payload/END frames from the UART receiver
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int                DATA_W      = WORD_W,
    parameter int                MAX_PAYLOAD = uart_rx_frame_ctrl_pkg::MAX_PAYLOAD,
    parameter int                TIMEOUT_CYC = uart_rx_frame_ctrl_pkg::TIMEOUT_CYC,
    parameter logic [DATA_W-1:0] START_MK    = uart_rx_frame_ctrl_pkg::START_MK,
    parameter logic [DATA_W-1:0] END_MK      = uart_rx_frame_ctrl_pkg::END_MK
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_done,
    input  logic [DATA_W-1:0]                rx_data,
    output logic                             wr_en,
    output logic [$clog2(MAX_PAYLOAD)-1:0]   wr_addr,
    output logic [DATA_W-1:0]                wr_data,
    output logic                             cmd_valid,
    output logic [DATA_W-1:0]                cmd_code,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] cmd_len,
    output logic                             frame_err,
    output logic                             busy
);

    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int LW = $clog2(MAX_PAYLOAD + 1);

    rx_frame_state_t   state, state_nxt;
    logic [LW-1:0]     remaining;
    logic [LW-1:0]     len_sh;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] code_sh;
    logic              ovf;
    logic              in_frame;
    logic              len_ok;
    logic              wr_nxt;
    logic              cmd_nxt;
    logic              err_nxt;

    assign len_ok = rx_data != '0 && rx_data <= DATA_W'(MAX_PAYLOAD + 1);

    cntr_rx_timeout_ovf #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk(clk),
        .rst(rst),
        .clr(rx_done || !in_frame),
        .en (in_frame),
        .ovf(ovf)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: a word always takes priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        state_nxt = rx_done && rx_data == START_MK ? GET_LEN : IDLE;
            GET_LEN:     state_nxt = rx_done ? (len_ok ? GET_CMD : ERR) : ovf ? ERR : state;
            GET_CMD:     state_nxt = rx_done ? (remaining == '0 ? GET_END : GET_PAYLOAD) : ovf ? ERR : state;
            GET_PAYLOAD: state_nxt = rx_done ? (remaining == LW'(1) ? GET_END : GET_PAYLOAD) : ovf ? ERR : state;
            GET_END:     state_nxt = rx_done ? (rx_data == END_MK ? ACCEPT : ERR) : ovf ? ERR : state;
            default:     state_nxt = IDLE;
        endcase
    end

    // decoded controls that feed the registered strobes and the timeout counter
    always_comb begin
        busy     = state != IDLE;
        in_frame = state inside {GET_LEN, GET_CMD, GET_PAYLOAD, GET_END};
        wr_nxt   = state == GET_PAYLOAD && rx_done;
        cmd_nxt  = state == ACCEPT;
        err_nxt  = state == ERR;
    end

    // registered strobes, write port, result registers and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_len   <= '0;
            frame_err <= 1'b0;
            remaining <= '0;
            len_sh    <= '0;
            idx       <= '0;
            code_sh   <= '0;
        end else begin
            wr_en     <= wr_nxt;
            cmd_valid <= cmd_nxt;
            frame_err <= err_nxt;
            if (wr_nxt) begin
                wr_addr   <= idx;
                wr_data   <= rx_data;
                idx       <= idx + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (cmd_nxt) begin
                cmd_code <= code_sh;
                cmd_len  <= len_sh;
            end
            if (state == GET_LEN && rx_done) begin
                remaining <= LW'(rx_data - 1'b1);
                len_sh    <= LW'(rx_data - 1'b1);
                idx       <= '0;
            end
            if (state == GET_CMD && rx_done)
                code_sh <= rx_data;
            if (err_nxt)
                idx <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames checked against a word-list frame model
module tb_uart_rx_frame_ctrl;

    localparam int T    = 5208;
    localparam int MAXP = 16;

    typedef struct {
        logic [31:0] c;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_en, cmd_valid, frame_err, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, cmd_code;
    logic [4:0] cmd_len;

    uart_rx_frame_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_len  (cmd_len),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  sw[$];
    int  sc[$];
    ev_t ew[$], ec[$], ee[$];
    ev_t ow[$], oc[$], oe[$];
    int  checks = 0;
    int  errors = 0;
    int  hold_code = 0;
    int  hold_len = 0;

    // observe DUT events between clock edges, stamped with the cycle they occupy
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) ow.push_back('{32'(cyc), 32'(wr_addr), 32'(wr_data)});
            if (cmd_valid) oc.push_back('{32'(cyc), 32'(cmd_code), 32'(cmd_len)});
            if (frame_err) oe.push_back('{32'(cyc), 32'(busy), 32'd0});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rg();
        return int'($urandom_range(2, 6));
    endfunction

    // one word on the receiver strobe; the next word starts gap cycles later
    task automatic send(input logic [7:0] w, input int gap);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = w;
        sw.push_back(int'(w));
        sc.push_back(cyc);
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    // frame model: walks the word list counting positions within a frame
    task automatic model(output int hz);
        bit inf = 0;
        int len = 0, n = 0, last = 0, ready = 0, code = 0;
        ew.delete(); ec.delete(); ee.delete();
        for (int i = 0; i < sw.size(); i++) begin
            int c, w;
            c = sc[i];
            w = sw[i];
            if (inf && c > last + T) begin
                ee.push_back('{32'(last + T + 2), 32'd0, 32'd0});
                ready = last + T + 2;
                inf = 0;
            end
            if (c < ready) continue;
            if (!inf) begin
                if (w == 'hFE) begin inf = 1; n = 0; last = c; end
                continue;
            end
            last = c;
            n++;
            if (n == 1) begin
                len = w;
                if (len < 1 || len > MAXP + 1) begin
                    ee.push_back('{32'(c + 2), 32'd0, 32'd0});
                    ready = c + 2;
                    inf = 0;
                end
            end else if (n == 2) begin
                code = w;
            end else if (n < len + 2) begin
                ew.push_back('{32'(c + 1), 32'(n - 3), 32'(w)});
            end else begin
                if (w == 'hEF) ec.push_back('{32'(c + 2), 32'(code), 32'(len - 1)});
                else ee.push_back('{32'(c + 2), 32'd0, 32'd0});
                ready = c + 2;
                inf = 0;
            end
        end
        hz = sc.size() > 0 ? sc[sc.size() - 1] + 6 : cyc + 2;
        if (inf) begin
            ee.push_back('{32'(last + T + 2), 32'd0, 32'd0});
            hz = last + T + 6;
        end
    endtask

    task automatic run_check();
        int hz;
        model(hz);
        while (cyc < hz) @(negedge clk);
        chk("wr_count", ow.size(), ew.size());
        for (int i = 0; i < ew.size() && i < ow.size(); i++) begin
            chk("wr_cycle", ow[i].c, ew[i].c);
            chk("wr_addr", ow[i].a, ew[i].a);
            chk("wr_data", ow[i].d, ew[i].d);
        end
        chk("cmd_count", oc.size(), ec.size());
        for (int i = 0; i < ec.size() && i < oc.size(); i++) begin
            chk("cmd_cycle", oc[i].c, ec[i].c);
            chk("cmd_code", oc[i].a, ec[i].a);
            chk("cmd_len", oc[i].d, ec[i].d);
        end
        chk("err_count", oe.size(), ee.size());
        for (int i = 0; i < ee.size() && i < oe.size(); i++) begin
            chk("err_cycle", oe[i].c, ee[i].c);
            chk("err_busy", oe[i].a, ee[i].a);
        end
        if (ec.size() > 0) begin
            hold_code = int'(ec[ec.size() - 1].a);
            hold_len  = int'(ec[ec.size() - 1].d);
        end
        chk("hold_code", cmd_code, hold_code);
        chk("hold_len", cmd_len, hold_len);
        chk("idle_busy", busy, 0);
        sw.delete(); sc.delete(); ow.delete(); oc.delete(); oe.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_code"}, cmd_code, 0);
        chk({tag, "_cmd_len"}, cmd_len, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // nominal frame
        send(8'hFE, 3); send(8'h04, 3); send(8'hA5, 3);
        send(8'h11, 3); send(8'h22, 3); send(8'h33, 3); send(8'hEF, 3);
        run_check();

        // zero payload, then LEN=0
        send(8'hFE, 2); send(8'h01, 2); send(8'h07, 2); send(8'hEF, 2);
        send(8'hFE, 2); send(8'h00, 2);
        run_check();

        // bad end marker followed by a good frame
        send(8'hFE, 2); send(8'h02, 2); send(8'hA5, 2); send(8'h11, 2); send(8'hEE, 2);
        send(8'hFE, 2); send(8'h01, 2); send(8'h07, 2); send(8'hEF, 2);
        run_check();

        // idle garbage, oversize length, maximum payload
        send(8'h00, 2); send(8'hFF, 2); send(8'hEF, 2);
        chk("garbage_busy", busy, 0);
        send(8'hFE, 2); send(8'h12, 2);
        send(8'hFE, 2); send(8'h11, 2); send(8'h5A, 2);
        for (int j = 0; j < 16; j++) send(8'(j * 17 + 3), 2);
        send(8'hEF, 2);
        run_check();

        // markers as data, then silence until the timeout fires
        send(8'hFE, 3); send(8'h03, 3); send(8'hA5, 3); send(8'hFE, 3);
        chk("frame_busy", busy, 1);
        run_check();

        // a word on the last allowed cycle keeps the frame alive
        send(8'hFE, 2); send(8'h01, 2); send(8'h07, T); send(8'hEF, 2);
        run_check();

        // one cycle later the frame has timed out and the word is dropped
        send(8'hFE, 2); send(8'h01, 2); send(8'h07, T + 1); send(8'hEF, 2);
        run_check();

        // asynchronous reset in the middle of the payload
        send(8'hFE, 3); send(8'h04, 3); send(8'hA5, 3); send(8'h11, 2);
        chk("pre_rst_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        sw.delete(); sc.delete(); ow.delete(); oc.delete(); oe.delete();
        hold_code = 0;
        hold_len = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (T + 20) @(negedge clk);
        chk("post_rst_wr", ow.size(), 0);
        chk("post_rst_cmd", oc.size(), 0);
        chk("post_rst_err", oe.size(), 0);
        send(8'hFE, 2); send(8'h02, 2); send(8'h3C, 2); send(8'h99, 2); send(8'hEF, 2);
        run_check();

        // random frames, some malformed, some preceded by idle garbage
        for (int k = 0; k < 24; k++) begin
            int len;
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 253)), rg());
            if ($urandom_range(0, 7) == 0)
                len = $urandom_range(0, 1) == 1 ? 0 : int'($urandom_range(18, 255));
            else
                len = int'($urandom_range(1, 17));
            send(8'hFE, rg());
            send(8'(len), rg());
            if (len >= 1 && len <= MAXP + 1) begin
                send(8'($urandom_range(0, 255)), rg());
                for (int j = 0; j < len - 1; j++) send(8'($urandom_range(0, 255)), rg());
                send($urandom_range(0, 4) == 0 ? 8'($urandom_range(0, 238)) : 8'hEF, rg());
            end
            if (k % 4 == 3) run_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
